// File: rtl/switch_debounce_pkg.sv
// Shared types and sizing helpers for the switch debouncer.
// Imported by debounce_channel and switch_debounce.
package switch_debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    VERIFY = 1'b1
  } db_state_t;

  // Ceiling log2 for sizing counters; never returns less than one bit.
  function automatic int db_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: two-flop synchroniser, STABLE/VERIFY FSM with a tick counter,
// registered clean level and one-cycle rise/fall pulses.
module debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = 20,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sw_raw,
  input  logic i_tick,
  output logic o_sw_clean,
  output logic o_rise_pulse,
  output logic o_fall_pulse,
  output logic o_commit
);

  localparam int             CW       = db_clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

  logic            r_sync1;
  logic            r_sync_in;
  db_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_clean;
  logic            r_rise;
  logic            r_fall;

  logic            w_differ;
  logic            w_commit;

  assign w_differ = (r_sync_in != r_clean);
  // Exposed combinationally so the top can register any_change in the same cycle as the pulses.
  assign w_commit = (r_state == VERIFY) && w_differ && i_tick && (r_cnt == CNT_LAST);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= RESET_VAL;
      r_sync_in <= RESET_VAL;
      r_state   <= STABLE;
      r_cnt     <= '0;
      r_clean   <= RESET_VAL;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync1   <= i_sw_raw;
      r_sync_in <= r_sync1;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      case (r_state)
        STABLE: begin
          if (w_differ) begin
            r_state <= VERIFY;
            r_cnt   <= '0;
          end
        end
        VERIFY: begin
          // Bounce back to the committed level wins over any tick in the same cycle.
          if (!w_differ) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (i_tick) begin
            if (r_cnt == CNT_LAST) begin
              r_clean <= r_sync_in;
              r_rise  <= r_sync_in;
              r_fall  <= ~r_sync_in;
              r_state <= STABLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_sw_clean   = r_clean;
  assign o_rise_pulse = r_rise;
  assign o_fall_pulse = r_fall;
  assign o_commit     = w_commit;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer: shared tick prescaler, WIDTH independent channels,
// and a registered any_change flag aligned with the per-channel pulses.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 20,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int            PW         = db_clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic             r_any_change;
  logic             w_tick;
  logic [WIDTH-1:0] w_commit;

  // With TICK_DIV=1 the counter sits at 0 == PRESC_LAST, so the tick is permanently high.
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_any_change <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_any_change <= |w_commit;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_VAL    (RESET_VAL[g])
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_sw_raw     (sw_raw[g]),
      .i_tick       (w_tick),
      .o_sw_clean   (sw_clean[g]),
      .o_rise_pulse (rise_pulse[g]),
      .o_fall_pulse (fall_pulse[g]),
      .o_commit     (w_commit[g])
    );
  end

  assign any_change = r_any_change;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed testbench for switch_debounce: one instance at TICK_DIV=4/STABLE_TICKS=3,
// one at TICK_DIV=1/STABLE_TICKS=5 for exact-latency and glitch checks.
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] sw_raw, sw_clean, rise_pulse, fall_pulse;
  logic       any_change;
  logic [9:0] sw_raw_g, sw_clean_g, rise_g, fall_g;
  logic       any_g;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH(10), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VAL(10'h000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .sw_clean(sw_clean),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
  );

  switch_debounce #(
    .WIDTH(10), .TICK_DIV(1), .STABLE_TICKS(5), .RESET_VAL(10'h000)
  ) dut_g (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw_g), .sw_clean(sw_clean_g),
    .rise_pulse(rise_g), .fall_pulse(fall_g), .any_change(any_g)
  );

  // Counts edges until sw_clean leaves old_val; n = max_cyc+1 marks a timeout.
  task automatic wait_change(input bit use_g, input logic [9:0] old_val, input int max_cyc,
                             output int n, output bit early);
    n = 0;
    early = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      n++;
      if (use_g ? (sw_clean_g !== old_val) : (sw_clean !== old_val)) return;
      if (use_g ? ((rise_g | fall_g) !== 10'h0 || any_g !== 1'b0)
                : ((rise_pulse | fall_pulse) !== 10'h0 || any_change !== 1'b0)) early = 1'b1;
    end
    n = max_cyc + 1;
  endtask

  task automatic test_reset();
    int n;
    bit early;
    reset_n  = 1'b0;
    sw_raw   = 10'h3FF;
    sw_raw_g = 10'h000;
    repeat (3) @(negedge clk);
    total++; if (sw_clean !== 10'h000) begin bad++; $display("FAIL reset_clean: got %h want 000", sw_clean); end
    total++; if ((rise_pulse | fall_pulse) !== 10'h000 || any_change !== 1'b0) begin
      bad++; $display("FAIL reset_pulses: rise=%h fall=%h any=%b want 0", rise_pulse, fall_pulse, any_change); end
    total++; if (sw_clean_g !== 10'h000) begin bad++; $display("FAIL reset_clean_g: got %h want 000", sw_clean_g); end
    reset_n = 1'b1;
    wait_change(1'b0, 10'h000, 30, n, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL reset_latency: got %0d want 12..15", n); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL reset_early_pulse: got %b want 0", early); end
    total++; if (sw_clean !== 10'h3FF) begin bad++; $display("FAIL reset_commit: got %h want 3ff", sw_clean); end
    total++; if (rise_pulse !== 10'h3FF || fall_pulse !== 10'h000 || any_change !== 1'b1) begin
      bad++; $display("FAIL reset_rise: rise=%h fall=%h any=%b want 3ff/000/1", rise_pulse, fall_pulse, any_change); end
    @(posedge clk); #1;
    total++; if (rise_pulse !== 10'h000 || any_change !== 1'b0) begin
      bad++; $display("FAIL reset_rise_width: rise=%h any=%b want 000/0", rise_pulse, any_change); end
  endtask

  task automatic test_release_all();
    int n;
    bit early;
    @(negedge clk); sw_raw = 10'h000;
    wait_change(1'b0, 10'h3FF, 30, n, early);
    total++; if (sw_clean !== 10'h000 || fall_pulse !== 10'h3FF || rise_pulse !== 10'h000) begin
      bad++; $display("FAIL release_all: clean=%h fall=%h rise=%h want 000/3ff/000", sw_clean, fall_pulse, rise_pulse); end
  endtask

  task automatic test_clean_step();
    int n;
    bit early;
    @(negedge clk); sw_raw = 10'h008;
    wait_change(1'b0, 10'h000, 30, n, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL step_latency: got %0d want 12..15", n); end
    total++; if (sw_clean !== 10'h008) begin bad++; $display("FAIL step_clean: got %h want 008", sw_clean); end
    total++; if (rise_pulse !== 10'h008 || fall_pulse !== 10'h000 || any_change !== 1'b1) begin
      bad++; $display("FAIL step_pulse: rise=%h fall=%h any=%b want 008/000/1", rise_pulse, fall_pulse, any_change); end
    @(posedge clk); #1;
    total++; if (rise_pulse !== 10'h000 || any_change !== 1'b0 || sw_clean !== 10'h008) begin
      bad++; $display("FAIL step_after: rise=%h any=%b clean=%h want 000/0/008", rise_pulse, any_change, sw_clean); end
  endtask

  task automatic test_bounce();
    int viol;
    int rises;
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); sw_raw[0] = ((i / 5) % 2 == 0);
      @(posedge clk); #1;
      if (sw_clean !== 10'h008 || (rise_pulse | fall_pulse) !== 10'h000) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL bounce_burst: got %0d bad cycles want 0", viol); end
    @(negedge clk); sw_raw[0] = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rise_pulse[0] === 1'b1) rises++;
    end
    total++; if (rises != 1) begin bad++; $display("FAIL bounce_rises: got %0d want 1", rises); end
    total++; if (sw_clean !== 10'h009) begin bad++; $display("FAIL bounce_final: got %h want 009", sw_clean); end
  endtask

  task automatic test_simultaneous();
    int n;
    bit early;
    @(negedge clk); sw_raw = 10'h00D;
    wait_change(1'b0, 10'h009, 30, n, early);
    total++; if (sw_clean !== 10'h00D || rise_pulse !== 10'h004) begin
      bad++; $display("FAIL simul_setup: clean=%h rise=%h want 00d/004", sw_clean, rise_pulse); end
    @(negedge clk); sw_raw = 10'h00B;
    wait_change(1'b0, 10'h00D, 30, n, early);
    total++; if (sw_clean !== 10'h00B) begin bad++; $display("FAIL simul_clean: got %h want 00b", sw_clean); end
    total++; if (rise_pulse !== 10'h002 || fall_pulse !== 10'h004 || any_change !== 1'b1) begin
      bad++; $display("FAIL simul_pulses: rise=%h fall=%h any=%b want 002/004/1", rise_pulse, fall_pulse, any_change); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL simul_early: got %b want 0", early); end
  endtask

  task automatic test_glitch_fast();
    int n;
    int viol;
    bit early;
    viol = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk); sw_raw_g = (i < 3) ? 10'h200 : 10'h000;
      @(posedge clk); #1;
      if (sw_clean_g !== 10'h000 || (rise_g | fall_g) !== 10'h000 || any_g !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL glitch_pass: got %0d bad cycles want 0", viol); end
    @(negedge clk); sw_raw_g = 10'h200;
    wait_change(1'b1, 10'h000, 20, n, early);
    total++; if (n != 8) begin bad++; $display("FAIL glitch_latency: got %0d want 8", n); end
    total++; if (sw_clean_g !== 10'h200 || rise_g !== 10'h200 || fall_g !== 10'h000 || any_g !== 1'b1) begin
      bad++; $display("FAIL glitch_commit: clean=%h rise=%h fall=%h any=%b want 200/200/000/1",
                      sw_clean_g, rise_g, fall_g, any_g); end
  endtask

  task automatic test_reset_mid_verify();
    int n;
    int viol;
    bit early;
    @(negedge clk); sw_raw = 10'h000;
    wait_change(1'b0, 10'h00B, 30, n, early);
    total++; if (sw_clean !== 10'h000 || fall_pulse !== 10'h00B) begin
      bad++; $display("FAIL mid_setup: clean=%h fall=%h want 000/00b", sw_clean, fall_pulse); end
    @(negedge clk); sw_raw = 10'h020;
    repeat (11) @(posedge clk);
    #1;
    total++; if (sw_clean !== 10'h000) begin bad++; $display("FAIL mid_precommit: got %h want 000", sw_clean); end
    @(negedge clk);
    reset_n  = 1'b0;
    sw_raw   = 10'h000;
    sw_raw_g = 10'h000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sw_clean !== 10'h000 || (rise_pulse | fall_pulse) !== 10'h000 || any_change !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL mid_quiet: got %0d bad cycles want 0", viol); end
    @(negedge clk); sw_raw = 10'h020;
    wait_change(1'b0, 10'h000, 30, n, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL mid_full_period: got %0d want 12..15", n); end
    total++; if (rise_pulse !== 10'h020 || sw_clean !== 10'h020) begin
      bad++; $display("FAIL mid_recommit: rise=%h clean=%h want 020/020", rise_pulse, sw_clean); end
  endtask

  initial begin
    test_reset();
    test_release_all();
    test_clean_step();
    test_bounce();
    test_simultaneous();
    test_glitch_fast();
    test_reset_mid_verify();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
